// File: rtl/tt_ctrl_seq_pkg.sv
// Shared types for the TinyTapeout mux-select controller.
// Holds the FSM state encoding and the timer-width helper.
package tt_ctrl_seq_pkg;

  typedef enum logic [2:0] {
    ST_SRST   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_INC_LO = 3'd2,
    ST_INC_HI = 3'd3,
    ST_ENA    = 3'd4,
    ST_ACTIVE = 3'd5
  } state_e;

  // Bits needed to hold the longest timed phase length.
  function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tt_ctrl_seq_timer.sv
// Loadable down-counter shared by all timed controller phases.
// done_c is high once the count reaches zero; the count then holds.
module tt_ctrl_seq_timer #(
  parameter int unsigned W       = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= W'(RST_VAL);
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - W'(1);
  end

  assign done_c = (cnt == '0);

endmodule

// File: rtl/tt_ctrl_seq.sv
// TinyTapeout mux-select sequencer: resets the chip select counter, pulses sel_inc up to the
// target address, then enables and releases the user design. Optional: TT_CTRL_SEQ_INCREMENTAL_EN.
module tt_ctrl_seq
  import tt_ctrl_seq_pkg::*;
#(
  parameter int unsigned MUX_W    = 5,
  parameter int unsigned BLK_W    = 5,
  parameter int unsigned INC_HI   = 1,
  parameter int unsigned INC_LO   = 1,
  parameter int unsigned SRST_CYC = 2,
  parameter int unsigned URST_CYC = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic [MUX_W+BLK_W-1:0]   req_addr,
  output logic                     req_ready,
  output logic                     ctrl_sel_rst_n,
  output logic                     ctrl_sel_inc,
  output logic                     ctrl_ena,
  output logic                     um_rst_n,
  output logic [MUX_W+BLK_W-1:0]   cur_addr,
  output logic                     active
);

  localparam int unsigned ADDR_W = MUX_W + BLK_W;
  localparam int unsigned TMR_W  = tmr_width(INC_HI, INC_LO, SRST_CYC, URST_CYC);
  localparam logic [TMR_W-1:0] SRST_LD = TMR_W'(SRST_CYC - 1);
  localparam logic [TMR_W-1:0] LO_LD   = TMR_W'(INC_LO - 1);
  localparam logic [TMR_W-1:0] HI_LD   = TMR_W'(INC_HI - 1);
  localparam logic [TMR_W-1:0] URST_LD = TMR_W'(URST_CYC - 1);

  state_e              state, state_d;
  logic                boot, boot_d;
  logic [ADDR_W-1:0]   tgt, tgt_d;
  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_val;
  logic                tmr_done_c;
  logic                accept_c;
  logic                sel_rst_n_d, inc_d, ena_d, um_rst_n_d, active_d, ready_d;
  logic [ADDR_W-1:0]   cur_d;

  assign accept_c = req_valid & req_ready;

  tt_ctrl_seq_timer #(.W(TMR_W), .RST_VAL(SRST_CYC - 1)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done_c   (tmr_done_c)
  );

  // Next state plus next values of every registered output (decoded from the next state).
  always_comb begin
    state_d  = state;
    boot_d   = boot;
    tgt_d    = tgt;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state)
      ST_SRST: if (tmr_done_c) begin
        boot_d = 1'b0;
        if (boot) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_INC_LO;
          tmr_load = 1'b1;
          tmr_val  = LO_LD;
        end
      end
      ST_IDLE: if (accept_c) begin
        tgt_d    = req_addr;
        state_d  = ST_SRST;
        tmr_load = 1'b1;
        tmr_val  = SRST_LD;
      end
      ST_INC_LO: if (tmr_done_c) begin
        tmr_load = 1'b1;
        if (cur_addr == tgt) begin
          state_d = ST_ENA;
          tmr_val = URST_LD;
        end else begin
          state_d = ST_INC_HI;
          tmr_val = HI_LD;
        end
      end
      ST_INC_HI: if (tmr_done_c) begin
        state_d  = ST_INC_LO;
        tmr_load = 1'b1;
        tmr_val  = LO_LD;
      end
      ST_ENA: if (tmr_done_c) state_d = ST_ACTIVE;
      ST_ACTIVE: if (accept_c) begin
        tgt_d    = req_addr;
        tmr_load = 1'b1;
`ifdef TT_CTRL_SEQ_INCREMENTAL_EN
        // Counting upward from the current position needs no counter reset.
        if (req_addr > cur_addr) begin
          state_d = ST_INC_LO;
          tmr_val = LO_LD;
        end else begin
          state_d = ST_SRST;
          tmr_val = SRST_LD;
        end
`else
        state_d = ST_SRST;
        tmr_val = SRST_LD;
`endif
      end
      default: state_d = ST_SRST;
    endcase

    sel_rst_n_d = (state_d != ST_SRST);
    inc_d       = (state_d == ST_INC_HI);
    ena_d       = (state_d == ST_ENA) || (state_d == ST_ACTIVE);
    um_rst_n_d  = (state_d == ST_ACTIVE);
    active_d    = (state_d == ST_ACTIVE);
    ready_d     = (state_d == ST_IDLE) || (state_d == ST_ACTIVE);
    cur_d       = cur_addr;
    if (state_d == ST_SRST)                        cur_d = '0;
    else if ((state == ST_INC_HI) && tmr_done_c)   cur_d = cur_addr + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_SRST;
      boot           <= 1'b1;
      tgt            <= '0;
      ctrl_sel_rst_n <= 1'b0;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
      um_rst_n       <= 1'b0;
      active         <= 1'b0;
      req_ready      <= 1'b0;
      cur_addr       <= '0;
    end else begin
      state          <= state_d;
      boot           <= boot_d;
      tgt            <= tgt_d;
      ctrl_sel_rst_n <= sel_rst_n_d;
      ctrl_sel_inc   <= inc_d;
      ctrl_ena       <= ena_d;
      um_rst_n       <= um_rst_n_d;
      active         <= active_d;
      req_ready      <= ready_d;
      cur_addr       <= cur_d;
    end
  end

endmodule

// File: tb/tb_tt_ctrl_seq.sv
// Bench for tt_ctrl_seq: models the chip's select counter from the pad pins and checks
// pulse counts, phase lengths and pad invariants over directed and random selections.
module tb_tt_ctrl_seq;

  localparam int unsigned AW   = 10;
  localparam int unsigned URST = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req_valid, req_valid2;
  logic [AW-1:0] req_addr, req_addr2;
  logic          req_ready, sel_rst_n, inc, ena, um_rst_n, active;
  logic          req_ready2, sel_rst_n2, inc2, ena2, um_rst_n2, active2;
  logic [AW-1:0] cur_addr, cur_addr2;

  tt_ctrl_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .ctrl_sel_rst_n(sel_rst_n), .ctrl_sel_inc(inc),
    .ctrl_ena(ena), .um_rst_n(um_rst_n), .cur_addr(cur_addr), .active(active)
  );

  tt_ctrl_seq #(.INC_HI(3), .INC_LO(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_addr(req_addr2),
    .req_ready(req_ready2), .ctrl_sel_rst_n(sel_rst_n2), .ctrl_sel_inc(inc2),
    .ctrl_ena(ena2), .um_rst_n(um_rst_n2), .cur_addr(cur_addr2), .active(active2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int chip_cnt = 0, chip_cnt2 = 0, pulse_cnt = 0;
  logic inc_q = 1'b0, inc2_q = 1'b0;
  bit srst_seen = 1'b0, rec2 = 1'b0;
  bit q2[$];
  int model_cur = 0;
  bit model_act = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample after the edge, update the chip-counter models, check pad invariants.
  task tick();
    @(posedge clk);
    #1;
    if (!sel_rst_n) chip_cnt = 0;
    else if (inc && !inc_q) begin chip_cnt++; pulse_cnt++; end
    if (!sel_rst_n) srst_seen = 1'b1;
    inc_q = inc;
    if (!sel_rst_n2) chip_cnt2 = 0;
    else if (inc2 && !inc2_q) chip_cnt2++;
    inc2_q = inc2;
    if (rec2) q2.push_back(inc2);
    chk("ena_with_inc", 32'(ena & inc), 0);
    chk("um_rst_without_ena", 32'(um_rst_n & ~ena), 0);
    chk("ena_with_inc_2", 32'(ena2 & inc2), 0);
    chk("um_rst_without_ena_2", 32'(um_rst_n2 & ~ena2), 0);
  endtask

  task automatic do_req(input int addr, input bit noise, input int abort_at);
    int  exp_p, k, ena_idx, url;
    bit  from_act, exp_srst;
    from_act = model_act;
    exp_srst = 1'b1;
    exp_p    = addr;
`ifdef TT_CTRL_SEQ_INCREMENTAL_EN
    if (from_act && addr > model_cur) begin
      exp_srst = 1'b0;
      exp_p    = addr - model_cur;
    end
`endif
    k = 0;
    while (!req_ready && k < 100) begin tick(); k++; end
    chk("ready_before_req", 32'(req_ready), 1);
    pulse_cnt = 0;
    srst_seen = 1'b0;
    req_valid = 1'b1;
    req_addr  = AW'(addr);
    tick();
    req_valid = 1'b0;
    if (from_act) begin
      chk("ena_drop", 32'(ena), 0);
      chk("active_drop", 32'(active), 0);
    end
    model_act = 1'b0;
    ena_idx = -1;
    url = 0;
    k = 0;
    while (!active && k < 2 * addr + 60) begin
      if (abort_at >= 0 && cur_addr == AW'(abort_at)) return;
      req_valid = noise && pulse_cnt >= 1 && pulse_cnt < addr - 1;
      req_addr  = AW'(7);
      tick();
      k++;
      if (ena && ena_idx < 0) ena_idx = k;
      if (ena && !um_rst_n) url++;
    end
    req_valid = 1'b0;
    chk("reach_active", 32'(active), 1);
    chk("pulse_count", pulse_cnt, exp_p);
    chk("chip_counter", chip_cnt, addr);
    chk("cur_addr", 32'(cur_addr), addr);
    chk("sel_rst_pulse", 32'(srst_seen), 32'(exp_srst));
    chk("um_rst_len", url, URST);
    chk("ena_active", 32'(ena), 1);
    chk("um_rst_high", 32'(um_rst_n), 1);
    if (addr == 0) chk("ena_latency_t0", ena_idx, 3);
    model_cur = addr;
    model_act = 1'b1;
  endtask

  initial begin
    int k, np;
    int rv[$];
    int rl[$];
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0;
    req_valid2 = 1'b0; req_addr2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vals", 32'({sel_rst_n, inc, ena, um_rst_n, active, req_ready, cur_addr}), 0);
    chk("reset_vals_2", 32'({sel_rst_n2, inc2, ena2, um_rst_n2, active2, req_ready2, cur_addr2}), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("srst_c1_ready", 32'(req_ready), 0);
    chk("srst_c1_selrst", 32'(sel_rst_n), 0);
    tick();
    chk("idle_ready", 32'(req_ready), 1);
    chk("idle_selrst", 32'(sel_rst_n), 1);
    chk("idle_ena", 32'(ena), 0);
    chk("idle_um_rst", 32'(um_rst_n), 0);

    // Slow-pulse instance: 4 pulses, 3 cycles high, 2 cycles low between them.
    q2.delete();
    rec2 = 1'b1;
    req_valid2 = 1'b1; req_addr2 = AW'(4);
    tick();
    req_valid2 = 1'b0;
    k = 0;
    while (!active2 && k < 200) begin tick(); k++; end
    rec2 = 1'b0;
    chk("d2_active", 32'(active2), 1);
    chk("d2_chip_counter", chip_cnt2, 4);
    for (int j = 0; j < q2.size(); j++) begin
      if (j == 0 || q2[j] != q2[j-1]) begin rv.push_back(int'(q2[j])); rl.push_back(1); end
      else rl[rl.size()-1]++;
    end
    np = 0;
    for (int j = 0; j < rv.size(); j++) begin
      if (rv[j] == 1) begin
        np++;
        chk("d2_inc_hi_len", rl[j], 3);
        if (np > 1) chk("d2_inc_lo_len", rl[j-1], 2);
      end
    end
    chk("d2_pulses", np, 4);

    do_req(384, 1'b0, -1);
    do_req(3, 1'b0, -1);
    do_req(9, 1'b0, -1);
    do_req(0, 1'b0, -1);
    do_req(1023, 1'b0, -1);
    for (int i = 0; i < 4; i++) do_req(int'($urandom_range(0, 300)), 1'b0, -1);
    do_req(50, 1'b1, -1);

    // Asynchronous reset in the middle of a pulse train.
    do_req(200, 1'b0, 100);
    chk("abort_point", 32'(cur_addr), 100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_vals", 32'({sel_rst_n, inc, ena, um_rst_n, active, req_ready, cur_addr}), 0);
    model_act = 1'b0;
    model_cur = 0;
    tick();
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(req_ready), 0);
    tick();
    chk("post_rst_idle", 32'(req_ready), 1);
    do_req(5, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
